// File: rtl/musb_bus_pkg.sv
// Shared definitions for the MUSB bus interconnect: bus widths, arbitration
// mode names, interconnect FSM states and the per-master request payload.
package musb_bus_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_WW = 4;

  localparam string ARB_RR    = "RR";
  localparam string ARB_FIXED = "FIXED";

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } bus_state_e;

  // Address / write data / byte enables presented by one master
  typedef struct packed {
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] data;
    logic [BUS_WW-1:0] wr;
  } bus_req_t;

endpackage

// File: rtl/musb_rr_arbiter.sv
// Request arbiter for the MUSB interconnect.
// Round-robin: the search starts at the pointer; fixed: the search starts at 0.
// The pointer moves to upd_idx+1 (mod NMASTERS) whenever upd is pulsed.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   req        - per-master request vector
//   upd        - transaction-end strobe
//   upd_idx    - index of the master whose transaction ended
//   gnt_idx    - binary index of the winning master (valid when valid=1)
//   valid      - at least one request present
module musb_rr_arbiter
  import musb_bus_pkg::*;
#(
  parameter int unsigned NMASTERS = 3,
  parameter string       ARB_MODE = "RR",
  localparam int unsigned IW      = (NMASTERS > 1) ? $clog2(NMASTERS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NMASTERS-1:0] req,
  input  logic                upd,
  input  logic [IW-1:0]       upd_idx,
  output logic [IW-1:0]       gnt_idx,
  output logic                valid
);

  localparam bit FIXED_MODE = (ARB_MODE == ARB_FIXED);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] base;

  function automatic logic [IW-1:0] mod_add(input logic [IW-1:0] a, input int unsigned b);
    return IW'((32'(a) + b) % NMASTERS);
  endfunction

  assign base = FIXED_MODE ? '0 : ptr_q;

  // First requester found walking upward from base, wrapping at NMASTERS
  always_comb begin
    valid   = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NMASTERS; i++) begin
      if (!valid && req[mod_add(base, i)]) begin
        valid   = 1'b1;
        gnt_idx = mod_add(base, i);
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (upd) begin
      ptr_q <= mod_add(upd_idx, 1);
    end
  end

endmodule

// File: rtl/musb_interconnect.sv
// MUSB shared-bus interconnect: arbitrates NMASTERS requesters onto one bus,
// decodes the granted address to one of NSLAVES targets, returns an error for
// unmapped addresses and for slaves that do not answer within TIMEOUT cycles.
// Ports:
//   clk, rst                          - clock, asynchronous active-low reset
//   master_address/data_i/wr/enable   - per-master request (packed, master 0 in LSBs)
//   master_data_o                     - shared read data (valid in ACCESS only)
//   master_ready, master_error        - per-master completion / error pulses
//   slave_address/data_o/wr           - request of the registered grant
//   slave_enable                      - one-hot slave select, ACCESS only
//   slave_data_i, slave_ready         - per-slave read data and completion
module musb_interconnect
  import musb_bus_pkg::*;
#(
  parameter int unsigned                NMASTERS   = 3,
  parameter int unsigned                NSLAVES    = 3,
  parameter logic [NSLAVES*BUS_AW-1:0]  MATCH_ADDR = {32'h1100_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLAVES*BUS_AW-1:0]  MATCH_MASK = {32'hFFFF_FFF8, 32'hFFFF_FFE0, 32'hFFFF_0000},
  parameter string                      ARB_MODE   = "RR",
  parameter int unsigned                TIMEOUT    = 255,
  localparam int unsigned MW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1,
  localparam int unsigned SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1,
  localparam int unsigned CW = $clog2(TIMEOUT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NMASTERS*BUS_AW-1:0]   master_address,
  input  logic [NMASTERS*BUS_DW-1:0]   master_data_i,
  input  logic [NMASTERS*BUS_WW-1:0]   master_wr,
  input  logic [NMASTERS-1:0]          master_enable,
  output logic [BUS_DW-1:0]            master_data_o,
  output logic [NMASTERS-1:0]          master_ready,
  output logic [NMASTERS-1:0]          master_error,
  output logic [BUS_AW-1:0]            slave_address,
  output logic [BUS_DW-1:0]            slave_data_o,
  output logic [BUS_WW-1:0]            slave_wr,
  output logic [NSLAVES-1:0]           slave_enable,
  input  logic [NSLAVES*BUS_DW-1:0]    slave_data_i,
  input  logic [NSLAVES-1:0]           slave_ready
);

  bus_req_t          m_req   [NMASTERS];
  logic [BUS_DW-1:0] s_rdata [NSLAVES];

  bus_state_e    state_q, state_d;
  logic [MW-1:0] gnt_q, gnt_d;
  logic [SW-1:0] slv_q, slv_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          arb_valid;
  logic [MW-1:0] arb_idx;
  logic          arb_upd;

  logic          dec_hit;
  logic [SW-1:0] dec_idx;

  // Unpack flat port vectors
  for (genvar i = 0; i < NMASTERS; i++) begin : g_mreq
    assign m_req[i].addr = master_address[i*BUS_AW +: BUS_AW];
    assign m_req[i].data = master_data_i[i*BUS_DW +: BUS_DW];
    assign m_req[i].wr   = master_wr[i*BUS_WW +: BUS_WW];
  end

  for (genvar k = 0; k < NSLAVES; k++) begin : g_srd
    assign s_rdata[k] = slave_data_i[k*BUS_DW +: BUS_DW];
  end

  musb_rr_arbiter #(
    .NMASTERS (NMASTERS),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (master_enable),
    .upd     (arb_upd),
    .upd_idx (gnt_q),
    .gnt_idx (arb_idx),
    .valid   (arb_valid)
  );

  // Address decode of the arbiter's candidate; lowest matching slave wins
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int unsigned k = 0; k < NSLAVES; k++) begin
      if (!dec_hit &&
          ((m_req[arb_idx].addr & MATCH_MASK[k*BUS_AW +: BUS_AW]) ==
           MATCH_ADDR[k*BUS_AW +: BUS_AW])) begin
        dec_hit = 1'b1;
        dec_idx = SW'(k);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      slv_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      slv_q   <= slv_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; arb_upd marks the end of every transaction
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    slv_d   = slv_q;
    cnt_d   = cnt_q;
    arb_upd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_idx;
          slv_d   = dec_idx;
          cnt_d   = '0;
          state_d = dec_hit ? ACCESS : ERROR;
        end
      end
      ACCESS: begin
        if (slave_ready[slv_q]) begin
          state_d = IDLE;
          arb_upd = 1'b1;
        end else if (!master_enable[gnt_q]) begin
          state_d = IDLE;
          arb_upd = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ERROR: begin
        state_d = IDLE;
        arb_upd = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs: request path always follows the registered grant
  always_comb begin
    slave_address = m_req[gnt_q].addr;
    slave_data_o  = m_req[gnt_q].data;
    slave_wr      = m_req[gnt_q].wr;
    slave_enable  = '0;
    master_ready  = '0;
    master_error  = '0;
    master_data_o = '0;
    if (state_q == ACCESS) begin
      slave_enable[slv_q] = 1'b1;
      master_ready[gnt_q] = slave_ready[slv_q];
      master_data_o       = s_rdata[slv_q];
    end
    if (state_q == ERROR) begin
      master_error[gnt_q] = 1'b1;
    end
  end

endmodule
